// File: rtl/uart_tx_buffered_sim.sv
// FIFO-buffered UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the parity_odd port and a PARITY bit period.
module uart_tx_buffered_sim #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        uart_clk,
  input  logic                        rstn,
  input  logic                        wr_valid,
  input  logic [DATA_BITS-1:0]        wr_data,
  output logic                        wr_ready,
`ifdef UART_TX_PARITY_EN
  input  logic                        parity_odd,
`endif
  output logic                        tx_out,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [15:0] CNT_LAST  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            cnt_reg, cnt_next;
  logic [3:0]             idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   tx_reg, tx_next;
  logic [LW-1:0]          level_reg;
  logic [PW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic                   pop, wr_en, bit_done;
`ifdef UART_TX_PARITY_EN
  logic                   par_reg;
`endif

  assign wr_ready = (level_reg != LW'(FIFO_DEPTH));
  assign wr_en    = rstn & wr_valid & wr_ready;
  assign tx_out   = tx_reg;
  assign busy     = (state_reg != IDLE) || (level_reg != '0);
  assign level    = level_reg;

  always_ff @(posedge uart_clk) begin
    if (!rstn) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      tx_reg     <= 1'b1;
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      tx_reg    <= tx_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (wr_en && !pop)
        level_reg <= level_reg + LW'(1);
      else if (!wr_en && pop)
        level_reg <= level_reg - LW'(1);
    end
  end

  // Storage and the pop-time read are kept reset-free so the array maps onto RAM.
  always_ff @(posedge uart_clk) begin
    if (wr_en) mem[wr_ptr_reg] <= wr_data;
    if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
      par_reg   <= (^mem[rd_ptr_reg]) ^ parity_odd;
`endif
    end else begin
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
    bit_done   = (cnt_reg == CNT_LAST);
    if (state_reg != IDLE) cnt_next = bit_done ? '0 : cnt_reg + 16'd1;
    case (state_reg)
      IDLE: pop = (level_reg != '0);
      START: if (bit_done) begin
        state_next = DATA;
        idx_next   = '0;
        tx_next    = shift_reg[0];
        shift_next = shift_reg >> 1;
      end
      DATA: if (bit_done) begin
        if (idx_reg == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
          tx_next    = par_reg;
`else
          state_next = STOP;
          tx_next    = 1'b1;
`endif
          idx_next   = '0;
        end else begin
          idx_next   = idx_reg + 4'd1;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_done) begin
        state_next = STOP;
        tx_next    = 1'b1;
        idx_next   = '0;
      end
`endif
      STOP: if (bit_done) begin
        // Chain straight into the next start bit when more data is queued.
        if (idx_reg == STOP_LAST) begin
          if (level_reg != '0) pop = 1'b1;
          else                 state_next = IDLE;
        end else begin
          idx_next = idx_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (pop) begin
      state_next = START;
      tx_next    = 1'b0;
      cnt_next   = '0;
      idx_next   = '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered_sim.sv
// Directed bench for uart_tx_buffered_sim: three parameterisations share one clock and reset.
`timescale 1ns/1ps
module tb_uart_tx_buffered_sim;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FA = 10 + PB;          // defaults frame length in bit periods
  localparam int LB = 144 + 16 * PB;    // low run for 0x00 at CLK_DIV=16
  localparam int FC = 11 + PB;          // nine-bit frame length

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
`ifdef UART_TX_PARITY_EN
  logic par_odd;
`endif
  logic       wv_a, rdy_a, tx_a, busy_a;
  logic [7:0] wd_a;
  logic [2:0] lvl_a;
  logic       wv_b, rdy_b, tx_b, busy_b;
  logic [7:0] wd_b;
  logic [2:0] lvl_b;
  logic       wv_c, rdy_c, tx_c, busy_c;
  logic [8:0] wd_c;
  logic [2:0] lvl_c;

  int vectors = 0;
  int fails = 0;

  uart_tx_buffered_sim dut_a (
    .uart_clk(clk), .rstn(rstn), .wr_valid(wv_a), .wr_data(wd_a), .wr_ready(rdy_a),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_out(tx_a), .busy(busy_a), .level(lvl_a));

  uart_tx_buffered_sim #(.DATA_BITS(8), .STOP_BITS(2), .CLK_DIV(16), .FIFO_DEPTH(4)) dut_b (
    .uart_clk(clk), .rstn(rstn), .wr_valid(wv_b), .wr_data(wd_b), .wr_ready(rdy_b),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_out(tx_b), .busy(busy_b), .level(lvl_b));

  uart_tx_buffered_sim #(.DATA_BITS(9)) dut_c (
    .uart_clk(clk), .rstn(rstn), .wr_valid(wv_c), .wr_data(wd_c), .wr_ready(rdy_c),
`ifdef UART_TX_PARITY_EN
    .parity_odd(par_odd),
`endif
    .tx_out(tx_c), .busy(busy_c), .level(lvl_c));

  task automatic test_reset;
    rstn = 1'b0;
    wv_a = 1'b1; wd_a = 8'h99;
    wv_b = 1'b0; wd_b = 8'h00;
    wv_c = 1'b0; wd_c = 9'h000;
`ifdef UART_TX_PARITY_EN
    par_odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    vectors++; if (tx_a !== 1'b1) begin fails++; $display("FAIL reset_tx_a: got %b expected 1", tx_a); end
    vectors++; if (rdy_a !== 1'b1) begin fails++; $display("FAIL reset_ready_a: got %b expected 1", rdy_a); end
    vectors++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy_a: got %b expected 0", busy_a); end
    vectors++; if (lvl_a !== 3'd0) begin fails++; $display("FAIL reset_level_a: got %0d expected 0", lvl_a); end
    vectors++; if (tx_b !== 1'b1 || busy_b !== 1'b0 || lvl_b !== 3'd0) begin
      fails++; $display("FAIL reset_b: tx=%b busy=%b level=%0d expected 1/0/0", tx_b, busy_b, lvl_b); end
    vectors++; if (tx_c !== 1'b1 || busy_c !== 1'b0 || rdy_c !== 1'b1) begin
      fails++; $display("FAIL reset_c: tx=%b busy=%b ready=%b expected 1/0/1", tx_c, busy_c, rdy_c); end
    rstn = 1'b1;
    wv_a = 1'b0;
    @(negedge clk);
    vectors++; if (lvl_a !== 3'd0) begin fails++; $display("FAIL reset_write_ignored: level got %0d expected 0", lvl_a); end
    $display("test_reset: reset state checked");
  endtask

  task automatic test_a5;
    logic [10:0] exp_bits;
`ifdef UART_TX_PARITY_EN
    exp_bits = 11'b1_0_1010_0101_0;
`else
    exp_bits = 11'b0_1_1010_0101_0;
`endif
    wv_a = 1'b1; wd_a = 8'hA5;
    @(negedge clk);
    wv_a = 1'b0;
    vectors++; if (lvl_a !== 3'd1) begin fails++; $display("FAIL a5_stored: level got %0d expected 1", lvl_a); end
    vectors++; if (tx_a !== 1'b1) begin fails++; $display("FAIL a5_no_bypass: tx got %b expected 1", tx_a); end
    vectors++; if (busy_a !== 1'b1) begin fails++; $display("FAIL a5_busy_queued: got %b expected 1", busy_a); end
    for (int i = 0; i < FA; i++) begin
      @(negedge clk);
      vectors++; if (tx_a !== exp_bits[i]) begin
        fails++; $display("FAIL a5_bit%0d: tx got %b expected %b", i, tx_a, exp_bits[i]); end
      if (i == 0) begin
        vectors++; if (lvl_a !== 3'd0) begin fails++; $display("FAIL a5_popped: level got %0d expected 0", lvl_a); end
      end
    end
    @(negedge clk);
    vectors++; if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
      fails++; $display("FAIL a5_idle: tx=%b busy=%b expected 1/0", tx_a, busy_a); end
    $display("test_a5: frame 0xA5 checked");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [1:0] exp_par;
    exp_par = 2'b01;  // index = parity_odd; 0x07 has three ones
    for (int k = 0; k < 2; k++) begin
      par_odd = (k == 1);
      wv_a = 1'b1; wd_a = 8'h07;
      @(negedge clk);
      wv_a = 1'b0;
      @(negedge clk);
      par_odd = ~par_odd;  // after the pop edge, must not alter this frame
      repeat (9) @(negedge clk);
      vectors++; if (tx_a !== exp_par[k]) begin
        fails++; $display("FAIL parity_odd%0d: tx got %b expected %b", k, tx_a, exp_par[k]); end
      repeat (3) @(negedge clk);
      par_odd = 1'b0;
      $display("test_parity: parity_odd=%0d frame checked", k);
    end
  endtask
`endif

  task automatic test_back_to_back;
    logic [54:0] cap;
    logic [10:0] got, want;
    logic [7:0]  d;
    cap = '0;
    for (int c = 0; c <= 2 + 5 * FA; c++) begin
      @(negedge clk);
      if (c == 5) begin
        vectors++; if (lvl_a !== 3'd4) begin fails++; $display("FAIL btb_full_level: got %0d expected 4", lvl_a); end
        vectors++; if (rdy_a !== 1'b0) begin fails++; $display("FAIL btb_full_ready: got %b expected 0", rdy_a); end
      end
      if (c == 1 + FA) begin
        vectors++; if (lvl_a !== 3'd4) begin fails++; $display("FAIL btb_hold_full: level got %0d expected 4", lvl_a); end
      end
      if (c == 2 + FA) begin
        vectors++; if (lvl_a !== 3'd3 || rdy_a !== 1'b1) begin
          fails++; $display("FAIL btb_drop_at_pop: level=%0d ready=%b expected 3/1", lvl_a, rdy_a); end
      end
      if (c == 2 + 5 * FA) begin
        vectors++; if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
          fails++; $display("FAIL btb_idle: busy=%b tx=%b expected 0/1", busy_a, tx_a); end
      end
      if (c >= 2 && c < 2 + 5 * FA) cap[c-2] = tx_a;
      if (c + 1 <= 5) begin
        wv_a = 1'b1; wd_a = 8'(c + 1);
      end else if (c + 1 <= 2 + FA) begin
        wv_a = 1'b1; wd_a = 8'h66;
      end else begin
        wv_a = 1'b0;
      end
    end
    for (int f = 0; f < 5; f++) begin
      d = 8'(f + 1);
      got = '0;
      for (int b = 0; b < FA; b++) got[b] = cap[f*FA + b];
`ifdef UART_TX_PARITY_EN
      want = {1'b1, ^d, d, 1'b0};
`else
      want = {1'b0, 1'b1, d, 1'b0};
`endif
      vectors++; if (got !== want) begin
        fails++; $display("FAIL btb_frame%0d: got %b expected %b", f, got, want); end
      $display("test_back_to_back: frame %0d (0x%02h) compared", f, d);
    end
  endtask

  task automatic test_reset_abort;
    int bad;
    wv_a = 1'b1; wd_a = 8'h3C;
    @(negedge clk); wd_a = 8'h11;
    @(negedge clk); wd_a = 8'h22;
    @(negedge clk);
    vectors++; if (lvl_a !== 3'd2) begin fails++; $display("FAIL abort_pre_level: got %0d expected 2", lvl_a); end
    vectors++; if (tx_a !== 1'b0) begin fails++; $display("FAIL abort_pre_data: tx got %b expected 0", tx_a); end
    rstn = 1'b0; wd_a = 8'h55;
    @(negedge clk);
    vectors++; if (tx_a !== 1'b1) begin fails++; $display("FAIL abort_tx: got %b expected 1", tx_a); end
    vectors++; if (lvl_a !== 3'd0) begin fails++; $display("FAIL abort_level: got %0d expected 0", lvl_a); end
    vectors++; if (busy_a !== 1'b0 || rdy_a !== 1'b1) begin
      fails++; $display("FAIL abort_flags: busy=%b ready=%b expected 0/1", busy_a, rdy_a); end
    rstn = 1'b1; wv_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin fails++; $display("FAIL abort_quiet: %0d active cycles, expected 0", bad); end
    $display("test_reset_abort: abort of 0x3C checked");
  endtask

  task automatic test_div16;
    int lows, highs;
    wv_b = 1'b1; wd_b = 8'h00;
    @(negedge clk);
    wv_b = 1'b0;
    lows = 0; highs = 0;
    for (int i = 0; i <= LB + 32; i++) begin
      @(negedge clk);
      if (i < LB && tx_b === 1'b0) lows++;
      if (i >= LB && i < LB + 32 && tx_b === 1'b1) highs++;
      if (i == LB + 31) begin
        vectors++; if (busy_b !== 1'b1) begin fails++; $display("FAIL div16_busy_stop: got %b expected 1", busy_b); end
      end
      if (i == LB + 32) begin
        vectors++; if (busy_b !== 1'b0 || tx_b !== 1'b1) begin
          fails++; $display("FAIL div16_idle: busy=%b tx=%b expected 0/1", busy_b, tx_b); end
      end
    end
    vectors++; if (lows != LB) begin fails++; $display("FAIL div16_low_run: got %0d expected %0d", lows, LB); end
    vectors++; if (highs != 32) begin fails++; $display("FAIL div16_stop_run: got %0d expected 32", highs); end
    $display("test_div16: frame 0x00 at CLK_DIV=16 checked");
  endtask

  task automatic test_nine_bits;
    int ones;
    for (int k = 0; k < 2; k++) begin
      wv_c = 1'b1; wd_c = (k == 0) ? 9'h1FF : 9'h100;
      @(negedge clk);
      wv_c = 1'b0;
      ones = 0;
      for (int i = 0; i <= FC; i++) begin
        @(negedge clk);
        if (i == 0) begin
          vectors++; if (tx_c !== 1'b0) begin fails++; $display("FAIL nine_start%0d: got %b expected 0", k, tx_c); end
        end
        if (i >= 1 && i <= 8 && tx_c === 1'b1) ones++;
        if (i == 9) begin
          vectors++; if (tx_c !== 1'b1) begin fails++; $display("FAIL nine_msb%0d: got %b expected 1", k, tx_c); end
        end
        if (i == FC) begin
          vectors++; if (busy_c !== 1'b0) begin fails++; $display("FAIL nine_idle%0d: busy got %b expected 0", k, busy_c); end
        end
      end
      vectors++; if (ones != ((k == 0) ? 8 : 0)) begin
        fails++; $display("FAIL nine_low8_%0d: ones got %0d expected %0d", k, ones, (k == 0) ? 8 : 0); end
      $display("test_nine_bits: frame 0x%03h checked", wd_c);
    end
  endtask

  initial begin
    test_reset();
    test_a5();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_reset_abort();
    test_div16();
    test_nine_bits();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
